gpio: RTL and testbench
=======================

GPIO -- requirements
Module: gpio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning pin count, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth, legal range 2..3.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sel_in  input  1  bus select for this block's address window.
REQ-006 SHALL have port write_mask_in  input  4  byte-lane write enables; bit k covers data bits 8k+7:8k.
REQ-007 SHALL have port address_in  input  32  byte address; only bits [4:2] decoded.
REQ-008 SHALL have port write_value_in  input  32  write data.
REQ-009 SHALL have port read_value_out  output  32  registered read data; zero when not selected, so it can be ORed onto the shared bus.
REQ-010 SHALL have port gpio_in  input  WIDTH  asynchronous pin inputs.
REQ-011 SHALL have port gpio_out  output  WIDTH  pin output values.
REQ-012 SHALL have port gpio_oe  output  WIDTH  pin output enables; 1 = drive.
REQ-013 SHALL have port irq_out  output  1  level interrupt request.

Function
REQ-014 SHALL decode address_in[4:2]: 0 OUT (RW), 1 DIR (RW), 2 IN (RO), 3 EDGE (RW1C), 4 IRQ_EN (RW); offsets 5..7 read 0 and ignore writes.
REQ-015 SHALL perform a write only when sel_in=1, applying only the lanes set in write_mask_in; bits at or above WIDTH are ignored on write and read as 0.
REQ-016 SHALL drive gpio_out from OUT and gpio_oe from DIR directly, so a write is visible on pins the cycle after the write edge.
REQ-017 SHALL pass gpio_in through a SYNC_STAGES-deep flop chain; IN returns the chain output.
REQ-018 SHALL register read data: with sel_in=1 at edge N, read_value_out holds the addressed register from edge N until edge N+1; with sel_in=0 at edge N it is 0 after edge N.
REQ-019 SHALL return the pre-write value when a register is read and written at the same edge.
REQ-020 SHALL detect a rising edge per bit as (sync output=1) AND (previous sync output=0), registered one stage after the synchroniser.
REQ-021 SHALL set the matching EDGE bit on a detected edge; the bit stays set until cleared.
REQ-022 SHALL clear an EDGE bit when it is written with 1 in an enabled lane; writing 0 has no effect.
REQ-023 SHALL give set priority over clear when an edge and a W1C hit the same bit at the same edge.
REQ-024 SHALL drive irq_out = OR over bits of (EDGE AND IRQ_EN), combinationally from registers only.
REQ-025 SHALL mask edge detection for SYNC_STAGES+1 cycles after reset release, using a saturating counter, so pins high at reset create no spurious EDGE bits.
REQ-026 SHALL set an EDGE bit from a pin change at edge M+SYNC_STAGES+1, where M is the first edge sampling the new level.

Reset
REQ-027 SHALL, while reset_n=0, clear OUT, DIR, EDGE, IRQ_EN, the synchroniser chain, the previous-sample register, the mask counter and read_value_out; gpio_out=0, gpio_oe=0, irq_out=0.
REQ-028 SHALL treat reset asserted mid-operation, including during a write, as an immediate return to the reset state with no partial write retained.

Verification
REQ-029 SHALL cover, with WIDTH=8: write 0x0000_00A5 mask 0001 to offset 0 -> gpio_out=0xA5 next cycle; read offset 0 returns 0xA5; mask 0000 leaves it unchanged.
REQ-030 SHALL cover: gpio_in 0x00->0x0F, SYNC_STAGES=2 -> IN reads 0x0F two edges later; EDGE=0x0F at edge M+3.
REQ-031 SHALL cover: IRQ_EN=0x01, EDGE=0x03 -> irq_out=1; write 0x01 to EDGE -> EDGE=0x02, irq_out=0.
REQ-032 SHALL cover: a new bit-0 edge and a W1C of bit 0 at the same edge -> EDGE bit 0 remains 1.
REQ-033 SHALL cover: gpio_in=0xFF held through reset release -> EDGE stays 0x00; a later 0->1 on bit 7 sets EDGE=0x80.
REQ-034 SHALL cover: reset_n pulsed low mid-write to DIR -> gpio_oe=0 asynchronously; a read of offset 5 returns 0; a read with sel_in=0 gives read_value_out=0.

Source files
------------

// File: rtl/gpio.sv
// General-purpose I/O block with byte-lane register writes.
// It has a configurable-depth input synchroniser and rising-edge capture
// into a sticky EDGE register (write-1-to-clear).
// The interrupt request is level-sensitive, gated per bit by IRQ_EN.
// Read data is registered and forced to zero when the block is not selected,
// so several slaves can share one ORed read bus.
module gpio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sel_in,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      address_in,
    input  logic [31:0]      write_value_in,
    output logic [31:0]      read_value_out,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_out
);

    // Register offsets, decoded from address bits [4:2]
    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_DIR    = 3'd1;
    localparam logic [2:0] OFF_IN     = 3'd2;
    localparam logic [2:0] OFF_EDGE   = 3'd3;
    localparam logic [2:0] OFF_IRQ_EN = 3'd4;

    // Edge capture stays blind for this many edges after reset release.
    // This lets the synchroniser fill, and lets the previous-sample register
    // catch up to pins that were already high during reset.
    localparam int MASK_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W       = $clog2(MASK_CYCLES + 1);

    // Zero-extend a pin-wide value onto the 32-bit read bus
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r           = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Merge write data into a register, honouring the per-bit lane mask
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] data,
                                               input logic [WIDTH-1:0] mask);
        return (cur & ~mask) | (data & mask);
    endfunction

    // Architectural registers
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_irq_en;

    // Input conditioning
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rise;
    logic [CNT_W-1:0] r_mask_cnt;

    // Bus side
    logic [31:0]      r_rdata;

    logic [2:0]       w_offset;
    logic [31:0]      w_lane_bits;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr_out;
    logic             w_wr_dir;
    logic             w_wr_edge;
    logic             w_wr_irq_en;
    logic [WIDTH-1:0] w_edge_clr;
    logic [WIDTH-1:0] w_sync_out;
    logic             w_mask_active;
    logic [31:0]      w_rdata;
    logic             w_unused_bits;

    assign w_offset = address_in[4:2];

    // Expand byte-lane enables to a per-bit mask
    always_comb begin
        w_lane_bits = '0;
        for (int k = 0; k < 4; k++) begin
            w_lane_bits[8*k +: 8] = {8{write_mask_in[k]}};
        end
    end

    // Bits at or above WIDTH are dropped here, so they never reach a register
    assign w_wmask = w_lane_bits[WIDTH-1:0];
    assign w_wdata = write_value_in[WIDTH-1:0];

    // Address bits outside [4:2] and data lanes beyond WIDTH carry no meaning
    assign w_unused_bits = ^{address_in[31:5], address_in[1:0], write_value_in, w_lane_bits};

    assign w_wr_out    = sel_in && (w_offset == OFF_OUT);
    assign w_wr_dir    = sel_in && (w_offset == OFF_DIR);
    assign w_wr_edge   = sel_in && (w_offset == OFF_EDGE);
    assign w_wr_irq_en = sel_in && (w_offset == OFF_IRQ_EN);

    // Write-1-to-clear: only ones in enabled lanes clear EDGE bits
    assign w_edge_clr = w_wr_edge ? (w_wdata & w_wmask) : '0;

    assign w_sync_out    = r_sync[SYNC_STAGES-1];
    assign w_mask_active = (r_mask_cnt < CNT_W'(MASK_CYCLES));

    // Synchroniser chain for the asynchronous pin inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Saturating post-reset counter that blinds edge capture while inputs settle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask_cnt <= '0;
        end else if (w_mask_active) begin
            r_mask_cnt <= r_mask_cnt + CNT_W'(1);
        end
    end

    // Rising-edge detector, registered one stage after the synchroniser
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_rise <= '0;
        end else begin
            r_prev <= w_sync_out;
            r_rise <= w_mask_active ? '0 : (w_sync_out & ~r_prev);
        end
    end

    // OUT, DIR and IRQ_EN are plain read/write registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out    <= '0;
            r_dir    <= '0;
            r_irq_en <= '0;
        end else begin
            if (w_wr_out) begin
                r_out <= merge(r_out, w_wdata, w_wmask);
            end
            if (w_wr_dir) begin
                r_dir <= merge(r_dir, w_wdata, w_wmask);
            end
            if (w_wr_irq_en) begin
                r_irq_en <= merge(r_irq_en, w_wdata, w_wmask);
            end
        end
    end

    // Sticky EDGE register; a new edge wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | r_rise;
        end
    end

    // Read mux over the current (pre-write) register contents
    always_comb begin
        w_rdata = '0;
        case (w_offset)
            OFF_OUT:    w_rdata = zext(r_out);
            OFF_DIR:    w_rdata = zext(r_dir);
            OFF_IN:     w_rdata = zext(w_sync_out);
            OFF_EDGE:   w_rdata = zext(r_edge);
            OFF_IRQ_EN: w_rdata = zext(r_irq_en);
            default:    w_rdata = '0;
        endcase
    end

    // Registered read data, zero when deselected so the bus can be ORed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= sel_in ? w_rdata : '0;
        end
    end

    assign read_value_out = r_rdata;
    assign gpio_out       = r_out;
    assign gpio_oe        = r_dir;
    assign irq_out        = |(r_edge & r_irq_en);

endmodule

// File: tb/tb_gpio.sv
// Directed bench for gpio (WIDTH=8, SYNC_STAGES=2) with a behavioural reference
// model and hand-computed literal expectations.
module tb_gpio;

    localparam int W = 8;
    localparam int S = 2;

    logic        clk;
    logic        reset_n;
    logic        sel_in;
    logic [3:0]  write_mask_in;
    logic [31:0] address_in;
    logic [31:0] write_value_in;
    logic [31:0] read_value_out;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic        irq_out;

    int checks   = 0;
    int failures = 0;

    gpio #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sel_in         (sel_in),
        .write_mask_in  (write_mask_in),
        .address_in     (address_in),
        .write_value_in (write_value_in),
        .read_value_out (read_value_out),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out),
        .gpio_oe        (gpio_oe),
        .irq_out        (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents plus a history of pin samples.
    // A pin sampled new at edge M is visible in IN for reads at M+2,
    // and sets EDGE at M+3 unless the edge falls in the post-reset blind window.
    logic [31:0] m_out  = '0;
    logic [31:0] m_dir  = '0;
    logic [31:0] m_edge = '0;
    logic [31:0] m_ien  = '0;
    logic [31:0] m_rd   = '0;
    logic [W-1:0] hist[$];
    int          m_k = 0;
    logic [31:0] t_lm, t_rd, t_set, t_clr, t_smp3, t_smp4;
    logic [2:0]  t_off;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_out = '0; m_dir = '0; m_edge = '0; m_ien = '0; m_rd = '0;
            hist = {};
            for (int i = 0; i < 6; i++) hist.push_back('0);
            m_k = 0;
        end else begin
            hist.push_front(gpio_in);
            if (hist.size() > 8) void'(hist.pop_back());
            if (m_k < 100) m_k++;
            t_off = address_in[4:2];
            t_lm  = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                     {8{write_mask_in[1]}}, {8{write_mask_in[0]}}} & 32'h0000_00FF;
            case (t_off)
                3'd0: t_rd = m_out;
                3'd1: t_rd = m_dir;
                3'd2: t_rd = {24'd0, hist[2]};
                3'd3: t_rd = m_edge;
                3'd4: t_rd = m_ien;
                default: t_rd = '0;
            endcase
            m_rd   = sel_in ? t_rd : '0;
            t_smp3 = {24'd0, hist[3]};
            t_smp4 = {24'd0, hist[4]};
            t_set  = (m_k >= S + 3) ? (t_smp3 & ~t_smp4) : '0;
            t_clr  = (sel_in && t_off == 3'd3) ? (write_value_in & t_lm) : '0;
            m_edge = (m_edge & ~t_clr) | t_set;
            if (sel_in && t_off == 3'd0) m_out = (m_out & ~t_lm) | (write_value_in & t_lm);
            if (sel_in && t_off == 3'd1) m_dir = (m_dir & ~t_lm) | (write_value_in & t_lm);
            if (sel_in && t_off == 3'd4) m_ien = (m_ien & ~t_lm) | (write_value_in & t_lm);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: all outputs against the model on every falling edge
    always @(negedge clk) begin
        chk("model gpio_out", {24'd0, gpio_out}, m_out);
        chk("model gpio_oe", {24'd0, gpio_oe}, m_dir);
        chk("model irq_out", {31'd0, irq_out}, {31'd0, |(m_edge & m_ien)});
        chk("model read_value_out", read_value_out, m_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic s, input logic [2:0] off, input logic [3:0] m,
                       input logic [31:0] v);
        sel_in         = s;
        address_in     = {27'd0, off, 2'b00};
        write_mask_in  = m;
        write_value_in = v;
        tick();
        sel_in         = 1'b0;
        address_in     = '0;
        write_mask_in  = '0;
        write_value_in = '0;
    endtask

    initial begin
        sel_in = 1'b0; address_in = '0; write_mask_in = '0; write_value_in = '0;
        gpio_in = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        chk("reset gpio_out", {24'd0, gpio_out}, 32'h0);
        chk("reset gpio_oe", {24'd0, gpio_oe}, 32'h0);
        chk("reset irq_out", {31'd0, irq_out}, 32'h0);
        chk("reset read_value_out", read_value_out, 32'h0);
        reset_n = 1'b1;
        repeat (6) tick();

        // OUT write, readback, empty-mask and out-of-width lanes
        bus(1'b1, 3'd0, 4'b0001, 32'h0000_00A5);
        chk("out write", {24'd0, gpio_out}, 32'hA5);
        bus(1'b1, 3'd0, 4'b0000, 32'h0);
        chk("out readback", read_value_out, 32'h0000_00A5);
        bus(1'b1, 3'd0, 4'b0000, 32'h0000_005A);
        chk("out mask 0000", {24'd0, gpio_out}, 32'hA5);
        bus(1'b1, 3'd0, 4'b1110, 32'hFFFF_FF3C);
        chk("out upper lanes", {24'd0, gpio_out}, 32'hA5);

        // Read and write at the same edge returns the old value
        bus(1'b1, 3'd1, 4'b0001, 32'h0000_003C);
        chk("dir rw old", read_value_out, 32'h0);
        chk("dir pins", {24'd0, gpio_oe}, 32'h3C);
        bus(1'b1, 3'd1, 4'b1111, 32'hFFFF_FFF0);
        chk("dir rw old2", read_value_out, 32'h3C);
        bus(1'b1, 3'd1, 4'b0000, 32'h0);
        chk("dir width clip", read_value_out, 32'hF0);

        // Unmapped offsets read zero and ignore writes
        for (int off = 5; off < 8; off++) begin
            bus(1'b1, 3'(off), 4'b1111, 32'hFFFF_FFFF);
            bus(1'b1, 3'(off), 4'b0000, 32'h0);
            chk("unmapped read", read_value_out, 32'h0);
        end

        // Synchroniser latency and edge capture timing
        bus(1'b1, 3'd4, 4'b0001, 32'h0000_000F);
        gpio_in = 8'h0F;
        bus(1'b1, 3'd2, 4'b0000, 32'h0);
        chk("in at M", read_value_out, 32'h0);
        bus(1'b1, 3'd2, 4'b0000, 32'h0);
        chk("in at M+1", read_value_out, 32'h0);
        bus(1'b1, 3'd2, 4'b0000, 32'h0);
        chk("in at M+2", read_value_out, 32'h0F);
        chk("irq at M+2", {31'd0, irq_out}, 32'h0);
        bus(1'b1, 3'd3, 4'b0000, 32'h0);
        chk("edge read at M+3", read_value_out, 32'h0);
        chk("irq at M+3", {31'd0, irq_out}, 32'h1);
        bus(1'b1, 3'd3, 4'b0000, 32'h0);
        chk("edge after M+3", read_value_out, 32'h0F);

        // W1C and interrupt masking
        bus(1'b1, 3'd3, 4'b0001, 32'h0000_000C);
        bus(1'b1, 3'd4, 4'b0001, 32'h0000_0001);
        chk("irq en bit0", {31'd0, irq_out}, 32'h1);
        bus(1'b1, 3'd3, 4'b0001, 32'h0000_0001);
        chk("irq cleared", {31'd0, irq_out}, 32'h0);
        bus(1'b1, 3'd3, 4'b0000, 32'h0);
        chk("edge after w1c", read_value_out, 32'h02);
        bus(1'b1, 3'd3, 4'b0000, 32'h0000_0002);
        chk("w1c mask 0000", read_value_out, 32'h02);

        // Set beats clear on the same edge
        gpio_in = 8'h0E;
        repeat (5) tick();
        gpio_in = 8'h0F;
        tick();
        tick();
        tick();
        bus(1'b1, 3'd3, 4'b0001, 32'h0000_0001);
        chk("edge pre set/clr", read_value_out, 32'h02);
        bus(1'b1, 3'd3, 4'b0000, 32'h0);
        chk("set wins clear", read_value_out, 32'h03);
        bus(1'b1, 3'd3, 4'b0001, 32'h0000_0003);
        bus(1'b1, 3'd3, 4'b0000, 32'h0);
        chk("edge all clear", read_value_out, 32'h0);

        // Pins high through reset release do not create edges
        reset_n = 1'b0;
        gpio_in = 8'hFF;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        bus(1'b1, 3'd3, 4'b0000, 32'h0);
        chk("edge after high reset", read_value_out, 32'h0);
        gpio_in = 8'h7F;
        repeat (5) tick();
        gpio_in = 8'hFF;
        repeat (5) tick();
        bus(1'b1, 3'd3, 4'b0000, 32'h0);
        chk("edge bit7", read_value_out, 32'h80);

        // Reset in the middle of a DIR write
        bus(1'b1, 3'd1, 4'b0001, 32'h0000_003C);
        chk("dir before reset", {24'd0, gpio_oe}, 32'h3C);
        sel_in = 1'b1; address_in = 32'h4; write_mask_in = 4'b0001; write_value_in = 32'hFF;
        #3 reset_n = 1'b0;
        #1;
        chk("async oe clear", {24'd0, gpio_oe}, 32'h0);
        chk("async out clear", {24'd0, gpio_out}, 32'h0);
        tick();
        sel_in = 1'b0; address_in = '0; write_mask_in = '0; write_value_in = '0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("no partial write", {24'd0, gpio_oe}, 32'h0);
        bus(1'b1, 3'd5, 4'b0000, 32'h0);
        chk("offset5 read", read_value_out, 32'h0);
        bus(1'b1, 3'd1, 4'b0001, 32'h0000_0055);
        bus(1'b1, 3'd1, 4'b0000, 32'h0);
        chk("dir read 55", read_value_out, 32'h55);
        bus(1'b0, 3'd1, 4'b0000, 32'h0);
        chk("deselected read", read_value_out, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
